// File: rtl/game_ctrl_mc_if.sv
// Signal bundle between the sprite/keypad side and game_ctrl_mc.
// The bomb signals only exist when GAME_CTRL_BOMB_EN is defined.
interface game_ctrl_mc_if #(
  parameter int N_ENEMY = 4,
  parameter int LIFE_W  = 2,
  parameter int SCORE_W = 16
);
  logic               frame_start_i;
  logic               disp_i;
  logic               me_alpha_i;
  logic               bullet_alpha_i;
  logic [N_ENEMY-1:0] enemy_alpha_i;
  logic               bonus_alpha_i;
  logic               press_vali_i;
  logic               pause_i;
  logic [2:0]         game_status_o;
  logic [LIFE_W-1:0]  lives_o;
  logic [SCORE_W-1:0] score_o;
  logic               invincible_o;
  logic [N_ENEMY-1:0] crash_enemy_bullet_o;
  logic               crash_me_enemy_o;
  logic               crash_me_bonus_o;
`ifdef GAME_CTRL_BOMB_EN
  logic               bomb_i;
  logic [1:0]         bombs_o;
  logic               bomb_clear_o;
`endif

  modport master (
    output frame_start_i, disp_i, me_alpha_i, bullet_alpha_i, enemy_alpha_i,
           bonus_alpha_i, press_vali_i, pause_i,
`ifdef GAME_CTRL_BOMB_EN
    output bomb_i,
    input  bombs_o, bomb_clear_o,
`endif
    input  game_status_o, lives_o, score_o, invincible_o,
           crash_enemy_bullet_o, crash_me_enemy_o, crash_me_bonus_o
  );

  modport slave (
    input  frame_start_i, disp_i, me_alpha_i, bullet_alpha_i, enemy_alpha_i,
           bonus_alpha_i, press_vali_i, pause_i,
`ifdef GAME_CTRL_BOMB_EN
    input  bomb_i,
    output bombs_o, bomb_clear_o,
`endif
    output game_status_o, lives_o, score_o, invincible_o,
           crash_enemy_bullet_o, crash_me_enemy_o, crash_me_bonus_o
  );
endinterface

// File: rtl/game_ctrl_mc.sv
// Frame-synchronous multi-enemy game controller (clk_vga domain).
// Collects sprite overlaps over a frame as sticky flags, evaluates them at
// frame_start_i and drives game state, lives, saturating score and the
// invincibility window. Optional bomb feature: define GAME_CTRL_BOMB_EN.
module game_ctrl_mc #(
  parameter int N_ENEMY       = 4,
  parameter int LIFE_W        = 2,
  parameter int LIVES_INIT    = 3,
  parameter int SCORE_W       = 16,
  parameter int SCORE_INC     = 1,
  parameter int INVINC_FRAMES = 60
) (
  input logic           clk_vga,
  input logic           rst,
  game_ctrl_mc_if.slave bus
);

  typedef enum logic [2:0] {
    PRERUN = 3'd0,
    RUN    = 3'd1,
    HIT    = 3'd2,
    PAUSE  = 3'd3,
    OVER   = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(INVINC_FRAMES + 1);
  localparam int ADD_W = SCORE_W + 40;

  state_t             state_q, state_d, ret_q, ret_d;
  logic [LIFE_W-1:0]  lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_ENEMY-1:0] eb_q, eb_d, eb_pulse_q, eb_pulse_d;
  logic               me_q, me_d, bn_q, bn_d, pend_q, pend_d;
  logic               me_pulse_q, me_pulse_d, bn_pulse_q, bn_pulse_d;
  logic               active;
  logic [N_ENEMY-1:0] pix_eb, eb_eval;
  logic               pix_me, pix_bn;
  logic [4:0]         hits;
  logic [ADD_W-1:0]   sum;
`ifdef GAME_CTRL_BOMB_EN
  logic [1:0]         bombs_q, bombs_d;
  logic               clear_q, clear_d, bomb_use;
`endif

  // Next-state, flag accumulation, frame evaluation and pulse generation
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    lives_d    = lives_q;
    score_d    = score_q;
    cnt_d      = cnt_q;
    eb_d       = eb_q;
    me_d       = me_q;
    bn_d       = bn_q;
    pend_d     = pend_q | bus.pause_i;
    eb_pulse_d = '0;
    me_pulse_d = 1'b0;
    bn_pulse_d = 1'b0;
    hits       = '0;
    sum        = '0;
    active     = (state_q == RUN) || (state_q == HIT);
    pix_eb     = bus.disp_i ? (bus.enemy_alpha_i & {N_ENEMY{bus.bullet_alpha_i}}) : '0;
    pix_me     = bus.disp_i & bus.me_alpha_i & (|bus.enemy_alpha_i) & (state_q == RUN);
    pix_bn     = bus.disp_i & bus.me_alpha_i & bus.bonus_alpha_i;
    eb_eval    = eb_q;
`ifdef GAME_CTRL_BOMB_EN
    bombs_d    = bombs_q;
    bomb_use   = bus.bomb_i & active & ((bombs_q != 2'd0) | bn_pulse_q);
    clear_d    = bomb_use;
    if (bomb_use) eb_eval = '0;
    if (bomb_use && !bn_pulse_q) bombs_d = bombs_q - 2'd1;
    else if (!bomb_use && bn_pulse_q && bombs_q != 2'd3) bombs_d = bombs_q + 2'd1;
`endif
    for (int i = 0; i < N_ENEMY; i++) hits = hits + {4'd0, eb_eval[i]};

    case (state_q)
      PRERUN: begin
        pend_d = 1'b0;
        eb_d   = '0;
        me_d   = 1'b0;
        bn_d   = 1'b0;
        if (bus.press_vali_i) state_d = RUN;
      end
      OVER: begin
        pend_d = 1'b0;
        eb_d   = '0;
        me_d   = 1'b0;
        bn_d   = 1'b0;
        if (bus.press_vali_i) begin
          state_d = PRERUN;
          lives_d = LIFE_W'(LIVES_INIT);
          score_d = '0;
        end
      end
      PAUSE: begin
        eb_d = '0;
        me_d = 1'b0;
        bn_d = 1'b0;
        if (bus.frame_start_i && pend_q) begin
          state_d = ret_q;
          pend_d  = bus.pause_i;
        end
      end
      RUN, HIT: begin
        if (bus.frame_start_i) begin
          eb_pulse_d = eb_eval;
          bn_pulse_d = bn_q;
          sum = {{(ADD_W-SCORE_W){1'b0}}, score_q} + ADD_W'(hits) * ADD_W'(SCORE_INC);
          score_d = (sum[ADD_W-1:SCORE_W] != '0) ? '1 : sum[SCORE_W-1:0];
          eb_d   = pix_eb;
          me_d   = pix_me;
          bn_d   = pix_bn;
          pend_d = bus.pause_i;
          if (state_q == RUN && me_q) begin
            lives_d    = lives_q - LIFE_W'(1);
            me_pulse_d = 1'b1;
            if (lives_q == LIFE_W'(1)) begin
              state_d = OVER;
            end else begin
              state_d = HIT;
              cnt_d   = CNT_W'(INVINC_FRAMES);
            end
          end else if (pend_q) begin
            ret_d   = state_q;
            state_d = PAUSE;
          end else if (state_q == HIT) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
              state_d = RUN;
              cnt_d   = '0;
            end
          end
        end else begin
          eb_d = eb_q | pix_eb;
          me_d = me_q | pix_me;
          bn_d = bn_q | pix_bn;
        end
`ifdef GAME_CTRL_BOMB_EN
        if (bomb_use) eb_d = '0;
`endif
      end
      default: begin
        state_d = PRERUN;
        pend_d  = 1'b0;
        eb_d    = '0;
        me_d    = 1'b0;
        bn_d    = 1'b0;
      end
    endcase
  end

  // State, counters, sticky flags and registered pulses
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      state_q    <= PRERUN;
      ret_q      <= RUN;
      lives_q    <= LIFE_W'(LIVES_INIT);
      score_q    <= '0;
      cnt_q      <= '0;
      eb_q       <= '0;
      me_q       <= 1'b0;
      bn_q       <= 1'b0;
      pend_q     <= 1'b0;
      eb_pulse_q <= '0;
      me_pulse_q <= 1'b0;
      bn_pulse_q <= 1'b0;
`ifdef GAME_CTRL_BOMB_EN
      bombs_q    <= 2'd0;
      clear_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      lives_q    <= lives_d;
      score_q    <= score_d;
      cnt_q      <= cnt_d;
      eb_q       <= eb_d;
      me_q       <= me_d;
      bn_q       <= bn_d;
      pend_q     <= pend_d;
      eb_pulse_q <= eb_pulse_d;
      me_pulse_q <= me_pulse_d;
      bn_pulse_q <= bn_pulse_d;
`ifdef GAME_CTRL_BOMB_EN
      bombs_q    <= bombs_d;
      clear_q    <= clear_d;
`endif
    end
  end

  assign bus.game_status_o        = state_q;
  assign bus.lives_o              = lives_q;
  assign bus.score_o              = score_q;
  assign bus.invincible_o         = (state_q == HIT);
  assign bus.crash_enemy_bullet_o = eb_pulse_q;
  assign bus.crash_me_enemy_o     = me_pulse_q;
  assign bus.crash_me_bonus_o     = bn_pulse_q;
`ifdef GAME_CTRL_BOMB_EN
  assign bus.bombs_o              = bombs_q;
  assign bus.bomb_clear_o         = clear_q;
`endif

endmodule

// File: tb/tb_game_ctrl_mc.sv
// Directed bench for game_ctrl_mc with SCORE_INC=5 and short frames.
// Bomb steps are compiled in only when GAME_CTRL_BOMB_EN is defined.
module tb_game_ctrl_mc;
  logic clk_vga = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  game_ctrl_mc_if #(.N_ENEMY(4), .LIFE_W(2), .SCORE_W(16)) bus ();

  game_ctrl_mc #(
    .N_ENEMY(4), .LIFE_W(2), .LIVES_INIT(3), .SCORE_W(16),
    .SCORE_INC(5), .INVINC_FRAMES(60)
  ) dut (
    .clk_vga (clk_vga),
    .rst     (rst),
    .bus     (bus)
  );

  // Free-running pixel clock
  always #5 clk_vga = ~clk_vga;

  task automatic cycle();
    @(posedge clk_vga);
    #1;
  endtask

  // Drive one cycle of inputs, then return everything to idle
  task automatic applyStimulus(input logic fs, input logic disp, input logic me,
                               input logic bullet, input logic [3:0] en,
                               input logic bonus, input logic press, input logic pause);
    bus.frame_start_i  = fs;
    bus.disp_i         = disp;
    bus.me_alpha_i     = me;
    bus.bullet_alpha_i = bullet;
    bus.enemy_alpha_i  = en;
    bus.bonus_alpha_i  = bonus;
    bus.press_vali_i   = press;
    bus.pause_i        = pause;
    cycle();
    bus.frame_start_i  = 1'b0;
    bus.disp_i         = 1'b0;
    bus.me_alpha_i     = 1'b0;
    bus.bullet_alpha_i = 1'b0;
    bus.enemy_alpha_i  = 4'd0;
    bus.bonus_alpha_i  = 1'b0;
    bus.press_vali_i   = 1'b0;
    bus.pause_i        = 1'b0;
  endtask

  task automatic frameStart();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Directed sequence of game scenarios
  initial begin
    rst                = 1'b1;
    bus.frame_start_i  = 1'b0;
    bus.disp_i         = 1'b0;
    bus.me_alpha_i     = 1'b0;
    bus.bullet_alpha_i = 1'b0;
    bus.enemy_alpha_i  = 4'd0;
    bus.bonus_alpha_i  = 1'b0;
    bus.press_vali_i   = 1'b0;
    bus.pause_i        = 1'b0;
`ifdef GAME_CTRL_BOMB_EN
    bus.bomb_i         = 1'b0;
`endif
    cycle();
    cycle();
    rst = 1'b0;
    checkOutput("reset_status", 32'(bus.game_status_o), 32'd0);
    checkOutput("reset_lives", 32'(bus.lives_o), 32'd3);
    checkOutput("reset_score", 32'(bus.score_o), 32'd0);
    checkOutput("reset_invinc", 32'(bus.invincible_o), 32'd0);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("press_run", 32'(bus.game_status_o), 32'd1);

    // Single channel hit over five pixels
    frameStart();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0);
    checkOutput("no_pulse_midframe", 32'(bus.crash_enemy_bullet_o), 32'd0);
    frameStart();
    checkOutput("eb_pulse_ch2", 32'(bus.crash_enemy_bullet_o), 32'h4);
    checkOutput("score_one_hit", 32'(bus.score_o), 32'd5);
    cycle();
    checkOutput("eb_pulse_one_cycle", 32'(bus.crash_enemy_bullet_o), 32'd0);

    // Two channels in one frame
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0);
    frameStart();
    checkOutput("eb_pulse_ch03", 32'(bus.crash_enemy_bullet_o), 32'h9);
    checkOutput("score_two_hits", 32'(bus.score_o), 32'd15);

    // Life loss and invincibility window
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    frameStart();
    checkOutput("crash_me_pulse", 32'(bus.crash_me_enemy_o), 32'd1);
    checkOutput("lives_after_crash", 32'(bus.lives_o), 32'd2);
    checkOutput("status_hit", 32'(bus.game_status_o), 32'd2);
    checkOutput("invinc_hit", 32'(bus.invincible_o), 32'd1);
    for (int f = 0; f < 59; f++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
      frameStart();
      checkOutput("hit_window", 32'(bus.game_status_o), 32'd2);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    frameStart();
    checkOutput("run_after_window", 32'(bus.game_status_o), 32'd1);
    checkOutput("lives_kept_in_hit", 32'(bus.lives_o), 32'd2);

    // Pause: frame before pause is still scored
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("pause_waits_frame", 32'(bus.game_status_o), 32'd1);
    frameStart();
    checkOutput("status_pause", 32'(bus.game_status_o), 32'd3);
    checkOutput("score_before_pause", 32'(bus.score_o), 32'd20);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    frameStart();
    checkOutput("pause_hold", 32'(bus.game_status_o), 32'd3);
    checkOutput("pause_no_eb", 32'(bus.crash_enemy_bullet_o), 32'd0);
    checkOutput("pause_no_me", 32'(bus.crash_me_enemy_o), 32'd0);
    checkOutput("pause_lives", 32'(bus.lives_o), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    frameStart();
    checkOutput("resume_run", 32'(bus.game_status_o), 32'd1);
    frameStart();
    checkOutput("resume_score", 32'(bus.score_o), 32'd20);
    checkOutput("resume_no_eb", 32'(bus.crash_enemy_bullet_o), 32'd0);

    // Pause and crash in the same frame: crash wins
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    frameStart();
    checkOutput("crash_wins_status", 32'(bus.game_status_o), 32'd2);
    checkOutput("crash_wins_lives", 32'(bus.lives_o), 32'd1);
    checkOutput("crash_wins_pulse", 32'(bus.crash_me_enemy_o), 32'd1);
    frameStart();
    checkOutput("pause_dropped", 32'(bus.game_status_o), 32'd2);
    for (int f = 0; f < 58; f++) frameStart();
    checkOutput("hit_last_frame", 32'(bus.game_status_o), 32'd2);
    frameStart();
    checkOutput("run_again", 32'(bus.game_status_o), 32'd1);

    // Score saturation with all four channels hit each frame
    for (int f = 0; f < 3275; f++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
      frameStart();
    end
    checkOutput("score_near_max", 32'(bus.score_o), 32'd65520);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    frameStart();
    checkOutput("eb_pulse_all", 32'(bus.crash_enemy_bullet_o), 32'hF);
    checkOutput("score_saturate", 32'(bus.score_o), 32'd65535);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
    frameStart();
    checkOutput("score_stays_max", 32'(bus.score_o), 32'd65535);

    // Last life lost, then restart
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0);
    frameStart();
    checkOutput("over_status", 32'(bus.game_status_o), 32'd4);
    checkOutput("over_lives", 32'(bus.lives_o), 32'd0);
    checkOutput("over_pulse", 32'(bus.crash_me_enemy_o), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    frameStart();
    checkOutput("over_score_held", 32'(bus.score_o), 32'd65535);
    checkOutput("over_no_eb", 32'(bus.crash_enemy_bullet_o), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("restart_status", 32'(bus.game_status_o), 32'd0);
    checkOutput("restart_lives", 32'(bus.lives_o), 32'd3);
    checkOutput("restart_score", 32'(bus.score_o), 32'd0);

    // Frame start coinciding with an active overlap belongs to the new frame
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("rerun_status", 32'(bus.game_status_o), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
    checkOutput("coincide_not_now", 32'(bus.crash_enemy_bullet_o), 32'd0);
    frameStart();
    checkOutput("coincide_next", 32'(bus.crash_enemy_bullet_o), 32'h2);
    checkOutput("coincide_score", 32'(bus.score_o), 32'd5);

    // Bonus collection
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    frameStart();
    checkOutput("bonus_pulse", 32'(bus.crash_me_bonus_o), 32'd1);
    checkOutput("bonus_no_crash", 32'(bus.crash_me_enemy_o), 32'd0);

`ifdef GAME_CTRL_BOMB_EN
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    frameStart();
    cycle();
    checkOutput("bombs_two", 32'(bus.bombs_o), 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
    bus.bomb_i = 1'b1;
    cycle();
    bus.bomb_i = 1'b0;
    checkOutput("bomb_clear", 32'(bus.bomb_clear_o), 32'd1);
    checkOutput("bombs_one", 32'(bus.bombs_o), 32'd1);
    frameStart();
    checkOutput("bomb_no_eb", 32'(bus.crash_enemy_bullet_o), 32'd0);
    checkOutput("bomb_no_score", 32'(bus.score_o), 32'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
